// File: rtl/xps2rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, deframes odd-parity bytes into a small FIFO, bus-polled.
// Optional PS2RX_BREAK_FILTER_EN drops 0xF0 break prefixes together with the byte that follows them.
module xps2rx #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FIFO_ADDR_W = 2,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              ps2_clk,
  input  logic              ps2_data
);
  localparam int unsigned DEPTH = 1 << FIFO_ADDR_W;
  localparam int unsigned CNT_W = FIFO_ADDR_W + 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state, state_nxt;
  logic [2:0]         bit_cnt, bit_cnt_nxt;
  logic [7:0]         shreg, shreg_nxt;
  logic               par, par_nxt;
  logic [TMO_W-1:0]   tmo, tmo_nxt;
  logic               frame_ok_c, frame_err_c;

  logic               clk_s1, clk_s2, clk_d, dat_s1, dat_s2;
  logic               fall_c;

  logic [7:0]             mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   err, ovf;
  logic                   wr_c, flush_c, clr_c, pop_c, push_c, do_push_c;
  logic                   full_c, not_empty_c;
  logic [7:0]             head_c;
  logic                   unused_c;

  // Pin synchronisers; idle level of the PS/2 bus is high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall_c = clk_d & ~clk_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tmo     <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par     <= par_nxt;
      tmo     <= tmo_nxt;
    end
  end

  // Deframer; the inter-edge timeout takes priority over a coincident edge
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par;
    tmo_nxt     = '0;
    frame_ok_c  = 1'b0;
    frame_err_c = 1'b0;
    if (state != S_IDLE && tmo == TMO_W'(TIMEOUT_CYC)) begin
      state_nxt   = S_IDLE;
      frame_err_c = 1'b1;
    end else begin
      if (state != S_IDLE && !fall_c) tmo_nxt = tmo + TMO_W'(1);
      case (state)
        S_IDLE: begin
          if (fall_c && !dat_s2) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = '0;
          end
        end
        S_DATA: begin
          if (fall_c) begin
            shreg_nxt   = {dat_s2, shreg[7:1]};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nxt = S_PARITY;
          end
        end
        S_PARITY: begin
          if (fall_c) begin
            par_nxt   = dat_s2;
            state_nxt = S_STOP;
          end
        end
        S_STOP: begin
          if (fall_c) begin
            state_nxt = S_IDLE;
            if (dat_s2 && ^{shreg, par}) frame_ok_c  = 1'b1;
            else                         frame_err_c = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef PS2RX_BREAK_FILTER_EN
  logic skip, skip_nxt;

  // 0xF0 arms a one-shot skip of the following byte
  always_comb begin
    push_c   = 1'b0;
    skip_nxt = skip;
    if (frame_err_c || flush_c) begin
      skip_nxt = 1'b0;
    end else if (frame_ok_c) begin
      if (skip)                skip_nxt = 1'b0;
      else if (shreg == 8'hF0) skip_nxt = 1'b1;
      else                     push_c   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) skip <= 1'b0;
    else      skip <= skip_nxt;
  end
`else
  assign push_c = frame_ok_c;
`endif

  assign wr_c        = sel & we & addr;
  assign flush_c     = wr_c & data_in[0];
  assign clr_c       = wr_c & data_in[1];
  assign not_empty_c = (count != '0);
  assign full_c      = (count == CNT_W'(DEPTH));
  assign pop_c       = sel & ~we & ~addr & not_empty_c;
  assign do_push_c   = push_c & (~full_c | pop_c) & ~flush_c;
  assign head_c      = not_empty_c ? mem[rd_ptr] : 8'h00;
  assign unused_c    = ^data_in[DATA_W-1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (flush_c) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push_c) wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
        if (pop_c)     rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
        if (do_push_c && !pop_c)      count <= count + CNT_W'(1);
        else if (!do_push_c && pop_c) count <= count - CNT_W'(1);
      end
      // A new event outranks a same-cycle sticky clear
      err <= (err & ~clr_c) | frame_err_c;
      ovf <= (ovf & ~clr_c) | (push_c & full_c & ~pop_c & ~flush_c);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= shreg;
  end

  always_comb begin
    data_out = '0;
    if (addr) data_out = DATA_W'(count);
    else      data_out = DATA_W'({err, ovf, not_empty_c, head_c});
  end
endmodule

// File: tb/tb_xps2rx.sv
// Randomised self-checking bench for xps2rx against a queue-based model of the receiver and FIFO.
module tb_xps2rx;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 60;
  localparam int unsigned HALF  = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sel = 1'b0;
  logic          we = 1'b0;
  logic          addr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;

  always #5 clk = ~clk;

  xps2rx #(.DATA_W(DW), .FIFO_ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  logic [7:0] mq[$];
  logic       m_err = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_skip = 1'b0;
  bit         chk_en = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic [31:0] exp_out(input logic a);
    logic [7:0] h;
    if (a) return 32'(mq.size());
    h = 8'h00;
    if (mq.size() != 0) h = mq[0];
    return {21'd0, m_err, m_ovf, mq.size() != 0, h};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Continuous comparison whenever the bench is between frames
  always @(negedge clk) begin
    if (chk_en) check("status", data_out, exp_out(addr));
  end

  function automatic void model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_err  = 1'b1;
      m_skip = 1'b0;
      return;
    end
`ifdef PS2RX_BREAK_FILTER_EN
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    if (b == 8'hF0) begin
      m_skip = 1'b1;
      return;
    end
`endif
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(b);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    chk_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(frame_bits(b, bad_par, bad_stop), 11);
    tick(HALF);
    ps2_data = 1'b1;
    tick(4);
    model_frame(b, !bad_par && !bad_stop);
    chk_en = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int n);
    send_bits(frame_bits(b, 1'b0, 1'b0), n);
    ps2_data = 1'b1;
    tick(TMO + 10);
    m_err  = 1'b1;
    m_skip = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic bus_read(input logic a, output logic [31:0] v);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    @(negedge clk);
    #1 v = data_out;
    @(posedge clk);
    #2;
    if (!a && mq.size() != 0) void'(mq.pop_front());
    sel  = 1'b0;
    addr = 1'b0;
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d);
    sel     = 1'b1;
    we      = 1'b1;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #2;
    if (a) begin
      if (d[0]) begin
        mq.delete();
        m_skip = 1'b0;
      end
      if (d[1]) begin
        m_err = 1'b0;
        m_ovf = 1'b0;
      end
    end
    sel     = 1'b0;
    we      = 1'b0;
    addr    = 1'b0;
    data_in = '0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    int          op;
    tick(3);
    rst = 1'b1;
    tick(2);
    chk_en = 1'b1;
    check("reset_data", data_out, 32'h0);
    bus_read(1'b1, v);
    check("reset_count", v, 32'h0);

    send_frame(8'h1C, 1'b0, 1'b0);
    bus_read(1'b0, v);
    check("rx_1c", v, 32'h11C);
    bus_read(1'b0, v);
    check("rx_1c_empty", v, 32'h0);

    send_frame(8'h16, 1'b1, 1'b0);
    bus_read(1'b0, v);
    check("bad_parity", v, 32'h400);
    bus_write(1'b1, 32'h2);
    bus_read(1'b0, v);
    check("err_cleared", v, 32'h0);

    send_frame(8'h16, 1'b0, 1'b0);
    send_frame(8'h1E, 1'b0, 1'b0);
    send_frame(8'h26, 1'b0, 1'b0);
    send_frame(8'h25, 1'b0, 1'b0);
    send_frame(8'h2E, 1'b0, 1'b0);
    bus_read(1'b1, v);
    check("full_count", v, 32'd4);
    bus_read(1'b0, v);
    check("ovf_rd0", v, 32'h316);
    bus_read(1'b0, v);
    check("ovf_rd1", v, 32'h31E);
    bus_read(1'b0, v);
    check("ovf_rd2", v, 32'h326);
    bus_read(1'b0, v);
    check("ovf_rd3", v, 32'h325);
    bus_read(1'b0, v);
    check("ovf_sticky", v, 32'h200);
    bus_write(1'b1, 32'h2);

    send_partial(8'h45, 4);
    bus_read(1'b0, v);
    check("timeout_err", v, 32'h400);
    bus_write(1'b1, 32'h2);
    send_frame(8'h45, 1'b0, 1'b0);
    bus_read(1'b0, v);
    check("after_timeout", v, 32'h145);

    send_frame(8'h45, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h45, 1'b0, 1'b0);
    bus_read(1'b1, v);
`ifdef PS2RX_BREAK_FILTER_EN
    check("brk_count", v, 32'd1);
    bus_read(1'b0, v);
    check("brk_rd0", v, 32'h145);
`else
    check("brk_count", v, 32'd3);
    bus_read(1'b0, v);
    check("brk_rd0", v, 32'h145);
    bus_read(1'b0, v);
    check("brk_rd1", v, 32'h1F0);
    bus_read(1'b0, v);
    check("brk_rd2", v, 32'h145);
`endif

    send_frame(8'h1C, 1'b0, 1'b0);
    send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 5);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    ps2_data = 1'b1;
    mq.delete();
    m_err  = 1'b0;
    m_ovf  = 1'b0;
    m_skip = 1'b0;
    tick(2);
    chk_en = 1'b1;
    check("midrst_data", data_out, 32'h0);
    bus_read(1'b1, v);
    check("midrst_count", v, 32'h0);
    send_frame(8'h5A, 1'b0, 1'b0);
    bus_read(1'b0, v);
    check("after_midrst", v, 32'h15A);

    for (int it = 0; it < 180; it++) begin
      op = int'($urandom_range(0, 99));
      b  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = 8'hF0;
      if (op < 55) begin
        send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
      end else if (op < 85) begin
        logic a;
        logic [31:0] e;
        a = 1'($urandom_range(0, 1));
        e = exp_out(a);
        bus_read(a, v);
        check("rand_read", v, e);
      end else if (op < 95) begin
        bus_write(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 3)));
      end else begin
        send_partial(b, int'($urandom_range(1, 10)));
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
